signed_addsub_pipe: RTL
=======================

SIGNED_ADDSUB_PIPE -- requirements
Module: signed_addsub_pipe

Interface
REQ-001 Parameter AWIDTH, default 16: width of signed operand i_a, 2..32.
REQ-002 Parameter BWIDTH, default 16: width of signed operand i_b, 2..32.
REQ-003 Parameter OUTWID, default max(AWIDTH,BWIDTH)+1: width of o_res, 2..33.
REQ-004 Parameter LATENCY, default 1: register stages from input to output, 1..4.
REQ-005 Parameter SAT, default 0: 1 = saturate on overflow, 0 = two's-complement wrap.
REQ-006 i_clk  input  1: single clock; all state updates on rising edge.
REQ-007 i_rst_n  input  1: reset, asynchronous assert, active-low.
REQ-008 i_valid  input  1: operands and mode valid this cycle.
REQ-009 i_sub  input  1: 0 = a+b, 1 = a-b.
REQ-010 i_a  input  AWIDTH: signed operand A.
REQ-011 i_b  input  BWIDTH: signed operand B.
REQ-012 o_valid  output  1: o_res and o_ovf valid.
REQ-013 o_res  output  OUTWID: signed result.
REQ-014 o_ovf  output  1: full-precision result did not fit OUTWID (sticky per sample only, not accumulated).

Function
REQ-015 FULLW = max(AWIDTH,BWIDTH)+2; both operands sign-extended to FULLW before the operation.
REQ-016 Full result r = a+b (i_sub=0) or a-b (i_sub=1) in FULLW bits; exact for all inputs including a-(-2^(BWIDTH-1)).
REQ-017 Overflow: o_ovf=1 iff r < -2^(OUTWID-1) or r > 2^(OUTWID-1)-1; o_ovf=0 whenever OUTWID >= FULLW.
REQ-018 SAT=1 with overflow: o_res = 2^(OUTWID-1)-1 for positive r, -2^(OUTWID-1) for negative r.
REQ-019 SAT=0 with overflow: o_res = low OUTWID bits of r (wrap).
REQ-020 No overflow: o_res = r exactly, either SAT setting.
REQ-021 Stage 1 registers r-derived o_res/o_ovf and i_valid on the capturing edge; stages 2..LATENCY are plain delay registers.
REQ-022 o_valid asserts exactly LATENCY rising edges after the edge sampling i_valid=1; one output per accepted input, order preserved.
REQ-023 Fully pipelined: one new sample accepted every cycle; no back-pressure, no stall.
REQ-024 i_valid=0: a bubble propagates (o_valid=0 LATENCY cycles later); o_res/o_ovf hold their previous output value during bubbles (data registers load only when the stage's valid is 1).
REQ-025 Mode switching of i_sub between consecutive valid cycles takes effect per sample with no penalty.

Reset
REQ-026 While i_rst_n=0, all stage registers clear asynchronously: o_valid=0, o_res=0, o_ovf=0.
REQ-027 Reset mid-stream discards all in-flight samples; none emerge after release.
REQ-028 First sample accepted on first rising edge with i_rst_n=1 and i_valid=1; its output appears LATENCY edges later.

Verification
REQ-029 Defaults, LATENCY=1: a=100,b=-30,sub=0 -> next edge o_res=70,o_valid=1,o_ovf=0; then a=-32768,b=32767,sub=1 -> o_res=-65535,o_ovf=0.
REQ-030 AWIDTH=BWIDTH=8, OUTWID=8, SAT=1: a=100,b=100,add -> o_res=127,o_ovf=1; a=-100,b=100,sub -> o_res=-128,o_ovf=1; a=-128,b=-128,sub -> o_res=0,o_ovf=0.
REQ-031 Same widths, SAT=0: a=100,b=100,add -> o_res=-56,o_ovf=1; a=127,b=1,add -> o_res=-128,o_ovf=1.
REQ-032 LATENCY=3, stream valid=1,0,1,1 with results 5,x,-7,9 -> o_valid pattern 1,0,1,1 starting 3 edges after first input; o_res 5,5(held),-7,9.
REQ-033 LATENCY=3, three valid samples in flight, pull i_rst_n low between edges -> outputs zero immediately (no clock); after release with i_valid=0, o_valid stays 0 for 5 cycles.
REQ-034 Random: 10,000 samples, random i_valid/i_sub/operands per configuration (LATENCY 1..4, SAT 0/1, OUTWID 6..FULLW) checked against integer reference model with LATENCY-deep expected queue.

Source files
------------

// File: rtl/signed_addsub_pipe.sv
// Pipelined signed adder/subtractor with optional saturation.
// The operation is computed at full precision, then either clamped or wrapped
// into OUTWID bits. Stage 1 registers the result; the remaining stages are
// delay registers that load only when their incoming valid is set.
module signed_addsub_pipe #(
  parameter int AWIDTH  = 16,
  parameter int BWIDTH  = 16,
  parameter int OUTWID  = ((AWIDTH > BWIDTH) ? AWIDTH : BWIDTH) + 1,
  parameter int LATENCY = 1,
  parameter bit SAT     = 1'b0
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  input  logic                     i_sub,
  input  logic signed [AWIDTH-1:0] i_a,
  input  logic signed [BWIDTH-1:0] i_b,
  output logic                     o_valid,
  output logic signed [OUTWID-1:0] o_res,
  output logic                     o_ovf
);

  localparam int MAXW  = (AWIDTH > BWIDTH) ? AWIDTH : BWIDTH;
  localparam int FULLW = MAXW + 2;
  // Working width also covers OUTWID wider than FULLW, so the result is
  // simply sign-extended in that case and can never overflow.
  localparam int EXTW  = (FULLW > OUTWID) ? FULLW : OUTWID;
  localparam int TOPW  = EXTW - OUTWID + 1;

  logic signed [EXTW-1:0] a_ext;
  logic signed [EXTW-1:0] b_ext;
  logic signed [EXTW-1:0] r_full;
  logic [TOPW-1:0]        r_top;
  logic                   r_fits;
  logic [OUTWID-1:0]      res_s1;
  logic                   ovf_s1;

  logic [LATENCY-1:0] valid_q;
  logic [LATENCY-1:0] valid_d;
  logic [OUTWID-1:0]  res_q [LATENCY];
  logic [OUTWID-1:0]  res_d [LATENCY];
  logic [LATENCY-1:0] ovf_q;
  logic [LATENCY-1:0] ovf_d;

  // Full-precision add/sub, range check, and saturate-or-wrap selection.
  always_comb begin
    a_ext  = EXTW'(i_a);
    b_ext  = EXTW'(i_b);
    r_full = i_sub ? (a_ext - b_ext) : (a_ext + b_ext);
    // The result fits iff every bit from the OUTWID sign bit upward agrees.
    r_top  = r_full[EXTW-1:OUTWID-1];
    r_fits = (&r_top) | ~(|r_top);
    ovf_s1 = ~r_fits;
    if (r_fits || !SAT) begin
      res_s1 = r_full[OUTWID-1:0];
    end else if (r_full[EXTW-1]) begin
      res_s1 = {1'b1, {(OUTWID-1){1'b0}}};
    end else begin
      res_s1 = {1'b0, {(OUTWID-1){1'b1}}};
    end
  end

  // Next-state for the pipeline; data holds across bubbles.
  always_comb begin
    valid_d = valid_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    valid_d[0] = i_valid;
    if (i_valid) begin
      res_d[0] = res_s1;
      ovf_d[0] = ovf_s1;
    end
    for (int s = 1; s < LATENCY; s++) begin
      valid_d[s] = valid_q[s-1];
      if (valid_q[s-1]) begin
        res_d[s] = res_q[s-1];
        ovf_d[s] = ovf_q[s-1];
      end
    end
  end

  // Pipeline registers; reset discards everything in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= '0;
      ovf_q   <= '0;
      for (int s = 0; s < LATENCY; s++) begin
        res_q[s] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      res_q   <= res_d;
    end
  end

  assign o_valid = valid_q[LATENCY-1];
  assign o_res   = res_q[LATENCY-1];
  assign o_ovf   = ovf_q[LATENCY-1];

endmodule
